// File: rtl/mc_ctrl_fsm_if.sv
// Control-unit bus: IR opcode and datapath status in, datapath enables/selects and debug status out.
// master = control unit (mc_ctrl_fsm), slave = datapath side.
interface mc_ctrl_fsm_if;
  logic [5:0] Code;
  logic       Zero;
  logic       MemReady;
  logic       PCWre;
  logic       IRWre;
  logic       RegWre;
  logic       WrRegData;
  logic       ALUSrcB;
  logic       ALUM2Reg;
  logic       DataMemRW;
  logic       MemReq;
  logic [2:0] ALUOp;
  logic [1:0] PCSrc;
  logic [1:0] RegOut;
  logic [1:0] ExtSel;
  logic       Halted;
  logic       IllegalOp;
  logic       MemErr;
  logic [3:0] State;

  modport master (
    input  Code, Zero, MemReady,
    output PCWre, IRWre, RegWre, WrRegData, ALUSrcB, ALUM2Reg, DataMemRW, MemReq,
    output ALUOp, PCSrc, RegOut, ExtSel, Halted, IllegalOp, MemErr, State
  );

  modport slave (
    output Code, Zero, MemReady,
    input  PCWre, IRWre, RegWre, WrRegData, ALUSrcB, ALUM2Reg, DataMemRW, MemReq,
    input  ALUOp, PCSrc, RegOut, ExtSel, Halted, IllegalOp, MemErr, State
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU control unit: IF/ID/EXE/MEM/WB sequencing with configurable ALU latency,
// data-memory ready handshake with optional timeout, sticky HALT and illegal-opcode pulse.
//
// Handshake: MemReq is held high for every MEM cycle; the access completes on the rising
// edge where MemReady is 1 (MemReady is ignored when MEM_HANDSHAKE=0). MemReq never drops
// before completion except on timeout (MemErr) or reset.
module mc_ctrl_fsm #(
  parameter int unsigned EXE_CYCLES    = 1,
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned MEM_TIMEOUT   = 0
) (
  input logic          CLK,
  input logic          RST,
  mc_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_EXE_A = 4'd2,
    S_EXE_B = 4'd3,
    S_EXE_M = 4'd4,
    S_MEM   = 4'd5,
    S_WB_R  = 4'd6,
    S_WB_M  = 4'd7,
    S_HLT   = 4'd8
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000, OP_AND  = 6'b010001, OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000, OP_MOVE = 6'b100000, OP_SLT  = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000, OP_LW   = 6'b110001, OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000, OP_JR   = 6'b111001, OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [3:0] EXE_N = 4'(EXE_CYCLES);
  localparam logic [7:0] TO_N  = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [3:0] exe_cnt, exe_cnt_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;

  logic       legal;
  logic [2:0] dec_alu_op;
  logic       dec_alu_src_b;
  logic [1:0] dec_ext_sel;
  logic [1:0] dec_reg_out;
  logic       mem_rdy;

  assign mem_rdy   = bus.MemReady | ~MEM_HANDSHAKE;
  assign bus.State = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IF;
      exe_cnt  <= 4'd0;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      exe_cnt  <= exe_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Static opcode decode; gated to zero in IF below because Code is not yet valid there.
  always_comb begin
    legal         = 1'b1;
    dec_alu_op    = 3'b000;
    dec_alu_src_b = 1'b0;
    dec_ext_sel   = 2'd2;
    dec_reg_out   = 2'd2;
    case (bus.Code)
      OP_ADD, OP_AND, OP_OR, OP_MOVE, OP_J, OP_JR, OP_HALT: ;
      OP_SUB:  dec_alu_op = 3'b001;
      OP_BEQ:  dec_alu_op = 3'b001;
      OP_SLT:  dec_alu_op = 3'b010;
      OP_ADDI: begin dec_alu_src_b = 1'b1; dec_reg_out = 2'd1; end
      OP_ORI: begin
        dec_alu_op    = 3'b101;
        dec_alu_src_b = 1'b1;
        dec_ext_sel   = 2'd1;
        dec_reg_out   = 2'd1;
      end
      OP_SLL: begin
        dec_alu_op    = 3'b100;
        dec_alu_src_b = 1'b1;
        dec_ext_sel   = 2'd0;
      end
      OP_LW:   begin dec_alu_src_b = 1'b1; dec_reg_out = 2'd1; end
      OP_SW:   dec_alu_src_b = 1'b1;
      OP_JAL:  dec_reg_out = 2'd0;
      default: legal = 1'b0;
    endcase
    // AND shares the default ALUOp with ADD in the list above; give it its own code here.
    if (bus.Code == OP_AND) dec_alu_op = 3'b110;
    if (bus.Code == OP_OR)  dec_alu_op = 3'b101;
  end

  always_comb begin
    state_nxt     = state;
    exe_cnt_nxt   = exe_cnt;
    wait_cnt_nxt  = 8'd0;
    bus.PCWre     = 1'b0;
    bus.IRWre     = 1'b0;
    bus.RegWre    = 1'b0;
    bus.WrRegData = 1'b0;
    bus.ALUM2Reg  = 1'b0;
    bus.DataMemRW = 1'b0;
    bus.MemReq    = 1'b0;
    bus.PCSrc     = 2'd0;
    bus.Halted    = 1'b0;
    bus.IllegalOp = 1'b0;
    bus.MemErr    = 1'b0;
    bus.ALUOp     = 3'b000;
    bus.ALUSrcB   = 1'b0;
    bus.ExtSel    = 2'd0;
    bus.RegOut    = 2'd0;

    if (state != S_IF) begin
      bus.ALUOp   = dec_alu_op;
      bus.ALUSrcB = dec_alu_src_b;
      bus.ExtSel  = dec_ext_sel;
      bus.RegOut  = dec_reg_out;
    end

    case (state)
      S_IF: begin
        bus.IRWre = 1'b1;
        state_nxt = S_ID;
      end
      S_ID: begin
        bus.PCWre = legal && (bus.Code != OP_HALT);
        if (!legal) begin
          bus.IllegalOp = 1'b1;
          state_nxt     = S_IF;
        end else begin
          case (bus.Code)
            OP_J:    begin bus.PCSrc = 2'd3; state_nxt = S_IF; end
            OP_JAL:  begin bus.PCSrc = 2'd3; bus.RegWre = 1'b1; state_nxt = S_IF; end
            OP_JR:   begin bus.PCSrc = 2'd2; state_nxt = S_IF; end
            OP_HALT: state_nxt = S_HLT;
            OP_LW, OP_SW: state_nxt = S_EXE_M;
            OP_BEQ:  state_nxt = S_EXE_B;
            default: begin state_nxt = S_EXE_A; exe_cnt_nxt = 4'd1; end
          endcase
        end
      end
      S_EXE_A: begin
        if (exe_cnt == EXE_N) state_nxt = S_WB_R;
        else                  exe_cnt_nxt = exe_cnt + 4'd1;
      end
      S_EXE_B: begin
        if (bus.Zero) begin
          bus.PCSrc = 2'd1;
          bus.PCWre = 1'b1;
        end
        state_nxt = S_IF;
      end
      S_EXE_M: state_nxt = S_MEM;
      S_MEM: begin
        bus.MemReq    = 1'b1;
        bus.DataMemRW = (bus.Code == OP_SW);
        // Ready has priority over a timeout landing in the same cycle.
        if (mem_rdy) begin
          state_nxt = (bus.Code == OP_SW) ? S_IF : S_WB_M;
        end else if ((TO_N != 8'd0) && (wait_cnt == TO_N)) begin
          bus.MemErr = 1'b1;
          state_nxt  = S_IF;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      S_WB_R: begin
        bus.RegWre    = 1'b1;
        bus.WrRegData = 1'b1;
        state_nxt     = S_IF;
      end
      S_WB_M: begin
        bus.RegWre    = 1'b1;
        bus.WrRegData = 1'b1;
        bus.ALUM2Reg  = 1'b1;
        state_nxt     = S_IF;
      end
      S_HLT: begin
        bus.Halted = 1'b1;
        state_nxt  = S_HLT;
      end
      default: state_nxt = S_IF;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: two instances (EXE_CYCLES=1/no timeout, EXE_CYCLES=3/timeout 2)
// share stimulus; each step compares a packed snapshot of all outputs with a hand-written entry.
module tb_mc_ctrl_fsm;

  localparam int W = 24;

  localparam logic [9:0] F_NONE = 10'b0000000000;
  localparam logic [9:0] F_IF   = 10'b1000000000;
  localparam logic [9:0] F_PC   = 10'b0100000000;
  localparam logic [9:0] F_JAL  = 10'b0110000000;
  localparam logic [9:0] F_WBR  = 10'b0011000000;
  localparam logic [9:0] F_WBM  = 10'b0011001000;
  localparam logic [9:0] F_MRD  = 10'b0000100000;
  localparam logic [9:0] F_MWR  = 10'b0000110000;
  localparam logic [9:0] F_MERR = 10'b0000110100;
  localparam logic [9:0] F_HLT  = 10'b0000000010;
  localparam logic [9:0] F_ILL  = 10'b0000000001;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] code = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];
  logic [7:0]   base;

  mc_ctrl_fsm_if a_if ();
  mc_ctrl_fsm_if b_if ();

  assign a_if.Code = code;  assign a_if.Zero = zero;  assign a_if.MemReady = mem_ready;
  assign b_if.Code = code;  assign b_if.Zero = zero;  assign b_if.MemReady = mem_ready;

  mc_ctrl_fsm #(.EXE_CYCLES(1), .MEM_HANDSHAKE(1'b1), .MEM_TIMEOUT(0)) dut_a (
    .CLK(CLK), .RST(RST), .bus(a_if.master)
  );
  mc_ctrl_fsm #(.EXE_CYCLES(3), .MEM_HANDSHAKE(1'b1), .MEM_TIMEOUT(2)) dut_b (
    .CLK(CLK), .RST(RST), .bus(b_if.master)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // {State, IRWre, PCWre, RegWre, WrRegData, MemReq, DataMemRW, ALUM2Reg, MemErr, Halted,
  //  IllegalOp, ALUOp, ALUSrcB, ExtSel, RegOut, PCSrc}
  function automatic logic [W-1:0] obs(input bit sel);
    if (!sel)
      return {a_if.State, a_if.IRWre, a_if.PCWre, a_if.RegWre, a_if.WrRegData, a_if.MemReq,
              a_if.DataMemRW, a_if.ALUM2Reg, a_if.MemErr, a_if.Halted, a_if.IllegalOp,
              a_if.ALUOp, a_if.ALUSrcB, a_if.ExtSel, a_if.RegOut, a_if.PCSrc};
    else
      return {b_if.State, b_if.IRWre, b_if.PCWre, b_if.RegWre, b_if.WrRegData, b_if.MemReq,
              b_if.DataMemRW, b_if.ALUM2Reg, b_if.MemErr, b_if.Halted, b_if.IllegalOp,
              b_if.ALUOp, b_if.ALUSrcB, b_if.ExtSel, b_if.RegOut, b_if.PCSrc};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%06h exp=%06h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    RST       = 1'b1;
    code      = 6'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // IF entries carry no decode; every other state shows the opcode's static decode plus PCSrc.
  task automatic push(input logic [3:0] st, input logic [9:0] fl, input logic [1:0] pcsrc,
                      input logic rdy);
    exp_q.push_back({st, fl, (st == 4'd0) ? 8'd0 : base, (st == 4'd0) ? 2'd0 : pcsrc});
    rdy_q.push_back(rdy);
  endtask

  task automatic run_seq(input bit sel, input string name);
    int n = 0;
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      e         = exp_q.pop_front();
      mem_ready = rdy_q.pop_front();
      #1;
      check($sformatf("%s[%0d]", name, n), obs(sel), e);
      n++;
      @(negedge CLK);
    end
  endtask

  initial begin
    // reset values
    do_reset();
    #1;
    check("reset_a", obs(1'b0), {4'd0, F_IF, 10'd0});
    check("reset_b", obs(1'b1), {4'd0, F_IF, 10'd0});

    // ADD, EXE_CYCLES=1
    do_reset(); code = 6'b000000; base = 8'b000_0_10_10;
    push(0, F_IF, 0, 0); push(1, F_PC, 0, 0); push(2, F_NONE, 0, 0);
    push(6, F_WBR, 0, 0); push(0, F_IF, 0, 0);
    run_seq(1'b0, "add");

    // SUB, EXE_CYCLES=3
    do_reset(); code = 6'b000001; base = 8'b001_0_10_10;
    push(0, F_IF, 0, 0); push(1, F_PC, 0, 0);
    push(2, F_NONE, 0, 0); push(2, F_NONE, 0, 0); push(2, F_NONE, 0, 0);
    push(6, F_WBR, 0, 0); push(0, F_IF, 0, 0);
    run_seq(1'b1, "sub");

    // SLL, EXE_CYCLES=3
    do_reset(); code = 6'b011000; base = 8'b100_1_00_10;
    push(0, F_IF, 0, 0); push(1, F_PC, 0, 0);
    push(2, F_NONE, 0, 0); push(2, F_NONE, 0, 0); push(2, F_NONE, 0, 0);
    push(6, F_WBR, 0, 0); push(0, F_IF, 0, 0);
    run_seq(1'b1, "sll");

    // ORI, EXE_CYCLES=1
    do_reset(); code = 6'b010010; base = 8'b101_1_01_01;
    push(0, F_IF, 0, 0); push(1, F_PC, 0, 0); push(2, F_NONE, 0, 0);
    push(6, F_WBR, 0, 0); push(0, F_IF, 0, 0);
    run_seq(1'b0, "ori");

    // BEQ taken
    do_reset(); code = 6'b110100; zero = 1'b1; base = 8'b001_0_10_10;
    push(0, F_IF, 0, 0); push(1, F_PC, 0, 0); push(3, F_PC, 1, 0); push(0, F_IF, 0, 0);
    run_seq(1'b0, "beq_t");

    // BEQ not taken
    do_reset(); code = 6'b110100; zero = 1'b0; base = 8'b001_0_10_10;
    push(0, F_IF, 0, 0); push(1, F_PC, 0, 0); push(3, F_NONE, 0, 0); push(0, F_IF, 0, 0);
    run_seq(1'b0, "beq_n");

    // LW, four not-ready MEM cycles then ready
    do_reset(); code = 6'b110001; base = 8'b000_1_10_01;
    push(0, F_IF, 0, 0); push(1, F_PC, 0, 0); push(4, F_NONE, 0, 0);
    for (int i = 0; i < 4; i++) push(5, F_MRD, 0, 0);
    push(5, F_MRD, 0, 1); push(7, F_WBM, 0, 0); push(0, F_IF, 0, 0);
    run_seq(1'b0, "lw");

    // SW, ready on first MEM cycle: 4-cycle instruction
    do_reset(); code = 6'b110000; base = 8'b000_1_10_10;
    push(0, F_IF, 0, 0); push(1, F_PC, 0, 0); push(4, F_NONE, 0, 0);
    push(5, F_MWR, 0, 1); push(0, F_IF, 0, 0);
    run_seq(1'b0, "sw");

    // SW, timeout 2: MemErr on third MEM cycle, no writeback
    do_reset(); code = 6'b110000; base = 8'b000_1_10_10;
    push(0, F_IF, 0, 0); push(1, F_PC, 0, 0); push(4, F_NONE, 0, 0);
    push(5, F_MWR, 0, 0); push(5, F_MWR, 0, 0); push(5, F_MERR, 0, 0);
    push(0, F_IF, 0, 0); push(1, F_PC, 0, 0);
    run_seq(1'b1, "sw_to");

    // SW, ready arrives in the timeout cycle: ready wins
    do_reset(); code = 6'b110000; base = 8'b000_1_10_10;
    push(0, F_IF, 0, 0); push(1, F_PC, 0, 0); push(4, F_NONE, 0, 0);
    push(5, F_MWR, 0, 0); push(5, F_MWR, 0, 0); push(5, F_MWR, 0, 1);
    push(0, F_IF, 0, 0);
    run_seq(1'b1, "sw_race");

    // JAL
    do_reset(); code = 6'b111010; base = 8'b000_0_10_00;
    push(0, F_IF, 0, 0); push(1, F_JAL, 3, 0); push(0, F_IF, 0, 0);
    run_seq(1'b0, "jal");

    // JR
    do_reset(); code = 6'b111001; base = 8'b000_0_10_10;
    push(0, F_IF, 0, 0); push(1, F_PC, 2, 0); push(0, F_IF, 0, 0);
    run_seq(1'b0, "jr");

    // illegal opcode
    do_reset(); code = 6'b111110; base = 8'b000_0_10_10;
    push(0, F_IF, 0, 0); push(1, F_ILL, 0, 0); push(0, F_IF, 0, 0); push(1, F_ILL, 0, 0);
    run_seq(1'b0, "illegal");

    // HALT: sticky for 20 cycles, then asynchronous reset out of HLT
    do_reset(); code = 6'b111111; base = 8'b000_0_10_10;
    push(0, F_IF, 0, 0); push(1, F_NONE, 0, 0);
    for (int i = 0; i < 20; i++) push(8, F_HLT, 0, 0);
    run_seq(1'b0, "halt");
    #2 RST = 1'b1;
    #1 check("rst_hlt", obs(1'b0), {4'd0, F_IF, 10'd0});
    @(negedge CLK);
    RST = 1'b0;

    // reset in the middle of a LW MEM wait aborts it
    do_reset(); code = 6'b110001; base = 8'b000_1_10_01;
    push(0, F_IF, 0, 0); push(1, F_PC, 0, 0); push(4, F_NONE, 0, 0); push(5, F_MRD, 0, 0);
    run_seq(1'b0, "lw_pre");
    #2 RST = 1'b1;
    #1 check("rst_mem", obs(1'b0), {4'd0, F_IF, 10'd0});
    mem_ready = 1'b1;
    @(negedge CLK);
    #1 check("rst_mem_hold", obs(1'b0), {4'd0, F_IF, 10'd0});
    RST = 1'b0;

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
